// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage plus the IF/ID pipeline register of a 5-stage MIPS
// pipeline. It owns the PC and issues one outstanding request at a time on a
// req/ready instruction-memory port. If the front end is stalled when the
// response arrives, the word is parked in a buffer. Redirects resolved in
// decode squash wrong-path fetches, including a response that is still in
// flight.
//
// Ports
//   clk, rst            pipeline clock, synchronous active-high reset
//   stallF, stallD      hazard-unit stalls of fetch / decode
//   pcsrcD, pcbranchD   taken branch in decode and its target
//   jumpD, pcjumpD      jump in decode and its target (jump has priority)
//   inst_req/addr       memory request; addr is stable until inst_ready
//   inst_ready/rdata    memory response (may arrive in the request cycle)
//   instrD, pcD, pcplus4D, validD   IF/ID register (validD=0 is a bubble)
//
// state | meaning
// IDLE  | first cycle after reset, no request outstanding
// FETCH | request to addr_q outstanding
// KILL  | wrong-path request in flight; its response will be discarded
// BUF   | response captured in buf_q while the front end is held

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallF,
   input  logic        stallD,
   input  logic        pcsrcD,
   input  logic [31:0] pcbranchD,
   input  logic        jumpD,
   input  logic [31:0] pcjumpD,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_ready,
   input  logic [31:0] inst_rdata,
   output logic [31:0] instrD,
   output logic [31:0] pcD,
   output logic [31:0] pcplus4D,
   output logic        validD
);

   typedef enum logic [1:0] {IDLE, FETCH, KILL, BUF} state_t;

   state_t      state;
   logic [31:0] pc_f;
   logic [31:0] addr_q;
   logic [31:0] buf_q;
   logic        req_q;

   logic        hold;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] addr_plus4;
   logic        deliver;
   logic [31:0] deliver_data;

   assign hold       = stallF | stallD;
   // Only a real instruction in decode may redirect, and only when decode
   // is actually advancing.
   assign redirect   = (jumpD | pcsrcD) & validD & ~stallD;
   assign target     = jumpD ? pcjumpD : pcbranchD;
   assign addr_plus4 = addr_q + 32'd4;

   assign inst_req   = req_q;
   assign inst_addr  = addr_q;

   always_comb begin
      deliver      = 1'b0;
      deliver_data = buf_q;
      case (state)
         FETCH: begin
            if (inst_ready && !redirect && !hold) begin
               deliver      = 1'b1;
               deliver_data = inst_rdata;
            end
         end
         BUF: begin
            if (!redirect && !hold) begin
               deliver      = 1'b1;
               deliver_data = buf_q;
            end
         end
         default: begin
            deliver      = 1'b0;
            deliver_data = buf_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pc_f     <= RESET_PC;
         addr_q   <= RESET_PC;
         buf_q    <= 32'd0;
         req_q    <= 1'b0;
         instrD   <= 32'd0;
         pcD      <= 32'd0;
         pcplus4D <= 32'd0;
         validD   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               addr_q <= pc_f;
               req_q  <= 1'b1;
               state  <= FETCH;
            end
            FETCH: begin
               if (redirect) begin
                  pc_f <= target;
                  if (inst_ready) begin
                     // Response arrived with the redirect: drop it and
                     // issue the target right away.
                     addr_q <= target;
                  end else begin
                     // Address must stay stable until the memory answers.
                     state <= KILL;
                  end
               end else if (inst_ready) begin
                  if (!hold) begin
                     pc_f   <= addr_plus4;
                     addr_q <= addr_plus4;
                  end else begin
                     buf_q <= inst_rdata;
                     req_q <= 1'b0;
                     state <= BUF;
                  end
               end
            end
            KILL: begin
               if (redirect) begin
                  pc_f <= target;
               end
               if (inst_ready) begin
                  addr_q <= redirect ? target : pc_f;
                  state  <= FETCH;
               end
            end
            BUF: begin
               if (redirect) begin
                  pc_f   <= target;
                  addr_q <= target;
                  req_q  <= 1'b1;
                  state  <= FETCH;
               end else if (!hold) begin
                  pc_f   <= addr_plus4;
                  addr_q <= addr_plus4;
                  req_q  <= 1'b1;
                  state  <= FETCH;
               end
            end
            default: begin
               req_q <= 1'b0;
               state <= IDLE;
            end
         endcase

         // IF/ID: hold under decode stall, otherwise load the delivered
         // instruction or a bubble (bubbles keep the old PC fields).
         if (!(stallD && !redirect)) begin
            if (deliver) begin
               instrD   <= deliver_data;
               pcD      <= addr_q;
               pcplus4D <= addr_plus4;
               validD   <= 1'b1;
            end else begin
               instrD <= 32'd0;
               validD <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed bench for fetch_stage. Inputs are driven and outputs sampled on
// the falling edge; all DUT outputs are registered, so the values seen at a
// negedge are the ones produced by the preceding posedge.

module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stallF;
   logic        stallD;
   logic        pcsrcD;
   logic [31:0] pcbranchD;
   logic        jumpD;
   logic [31:0] pcjumpD;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_ready;
   logic [31:0] inst_rdata;
   logic [31:0] instrD;
   logic [31:0] pcD;
   logic [31:0] pcplus4D;
   logic        validD;

   int n_cmp = 0;
   int n_err = 0;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .stallF     (stallF),
      .stallD     (stallD),
      .pcsrcD     (pcsrcD),
      .pcbranchD  (pcbranchD),
      .jumpD      (jumpD),
      .pcjumpD    (pcjumpD),
      .inst_req   (inst_req),
      .inst_addr  (inst_addr),
      .inst_ready (inst_ready),
      .inst_rdata (inst_rdata),
      .instrD     (instrD),
      .pcD        (pcD),
      .pcplus4D   (pcplus4D),
      .validD     (validD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got timeout expected $finish");
      $fatal(1);
   end

   // Instruction word the bench's memory returns for a given address.
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'hA5C3_5A3C;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // One zero-wait fetch of address a, then check it landed in IF/ID.
   task automatic fetch_one(input logic [31:0] a);
      logic [31:0] nxt;
      nxt = a + 32'd4;
      chk("req", 32'(inst_req), 32'd1);
      chk("addr", inst_addr, a);
      inst_ready = 1'b1;
      inst_rdata = word_of(a);
      step();
      inst_ready = 1'b0;
      inst_rdata = 32'h0;
      chk("validD", 32'(validD), 32'd1);
      chk("pcD", pcD, a);
      chk("pcplus4D", pcplus4D, nxt);
      chk("instrD", instrD, word_of(a));
   endtask

   initial begin
      rst        = 1'b1;
      stallF     = 1'b0;
      stallD     = 1'b0;
      pcsrcD     = 1'b0;
      pcbranchD  = 32'h0;
      jumpD      = 1'b0;
      pcjumpD    = 32'h0;
      inst_ready = 1'b0;
      inst_rdata = 32'h0;
      step();
      step();

      // Reset values
      chk("rst_req", 32'(inst_req), 32'd0);
      chk("rst_addr", inst_addr, 32'h0);
      chk("rst_validD", 32'(validD), 32'd0);
      chk("rst_instrD", instrD, 32'h0);
      chk("rst_pcD", pcD, 32'h0);
      chk("rst_pcplus4D", pcplus4D, 32'h0);

      // Ready tied high through IDLE: IDLE issues no request.
      rst        = 1'b0;
      inst_ready = 1'b1;
      inst_rdata = 32'hDEAD_BEEF;
      step();
      chk("idle_validD", 32'(validD), 32'd0);

      // Back-to-back zero-wait fetches 0x0 .. 0xC
      for (int i = 0; i < 4; i++) fetch_one(32'(i * 4));

      // Three wait cycles at 0x10
      chk("w0_addr", inst_addr, 32'h10);
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("w_req", 32'(inst_req), 32'd1);
         chk("w_addr", inst_addr, 32'h10);
         chk("w_validD", 32'(validD), 32'd0);
      end
      fetch_one(32'h10);

      // Stalled response at 0x20 goes to the buffer
      fetch_one(32'h14);
      fetch_one(32'h18);
      fetch_one(32'h1C);
      chk("b_addr", inst_addr, 32'h20);
      inst_ready = 1'b1;
      inst_rdata = word_of(32'h20);
      stallF     = 1'b1;
      stallD     = 1'b1;
      step();
      inst_ready = 1'b0;
      inst_rdata = 32'h1234_5678;
      chk("b1_req", 32'(inst_req), 32'd0);
      chk("b1_validD", 32'(validD), 32'd1);
      chk("b1_pcD", pcD, 32'h1C);
      chk("b1_instrD", instrD, word_of(32'h1C));
      step();
      chk("b2_req", 32'(inst_req), 32'd0);
      chk("b2_pcD", pcD, 32'h1C);
      stallF = 1'b0;
      stallD = 1'b0;
      step();
      chk("b3_validD", 32'(validD), 32'd1);
      chk("b3_instrD", instrD, word_of(32'h20));
      chk("b3_pcD", pcD, 32'h20);
      chk("b3_req", 32'(inst_req), 32'd1);
      chk("b3_addr", inst_addr, 32'h24);

      // Jump while the request to 0x40 is waiting: KILL
      for (int i = 0; i < 7; i++) fetch_one(32'(32'h24 + i * 4));
      chk("k0_addr", inst_addr, 32'h40);
      jumpD   = 1'b1;
      pcjumpD = 32'h100;
      step();
      jumpD = 1'b0;
      chk("k1_req", 32'(inst_req), 32'd1);
      chk("k1_addr", inst_addr, 32'h40);
      chk("k1_validD", 32'(validD), 32'd0);
      step();
      chk("k2_addr", inst_addr, 32'h40);
      chk("k2_validD", 32'(validD), 32'd0);
      inst_ready = 1'b1;
      inst_rdata = word_of(32'h40);
      step();
      inst_ready = 1'b0;
      chk("k3_validD", 32'(validD), 32'd0);
      chk("k3_addr", inst_addr, 32'h100);
      fetch_one(32'h100);

      // Jump and branch together, response in the same cycle
      jumpD      = 1'b1;
      pcsrcD     = 1'b1;
      pcbranchD  = 32'h200;
      pcjumpD    = 32'h300;
      inst_ready = 1'b1;
      inst_rdata = word_of(32'h104);
      step();
      jumpD      = 1'b0;
      pcsrcD     = 1'b0;
      inst_ready = 1'b0;
      chk("jb_validD", 32'(validD), 32'd0);
      chk("jb_instrD", instrD, 32'h0);
      chk("jb_pcD", pcD, 32'h100);
      chk("jb_addr", inst_addr, 32'h300);
      fetch_one(32'h300);

      // Jump under stallD is ignored and IF/ID holds
      stallD  = 1'b1;
      jumpD   = 1'b1;
      pcjumpD = 32'h500;
      step();
      stallD = 1'b0;
      jumpD  = 1'b0;
      chk("sj_validD", 32'(validD), 32'd1);
      chk("sj_pcD", pcD, 32'h300);
      chk("sj_addr", inst_addr, 32'h304);
      fetch_one(32'h304);

      // Branch-only redirect to 0x80 with same-cycle response
      pcsrcD     = 1'b1;
      pcbranchD  = 32'h80;
      pcjumpD    = 32'h999;
      inst_ready = 1'b1;
      inst_rdata = word_of(32'h308);
      step();
      pcsrcD     = 1'b0;
      inst_ready = 1'b0;
      chk("br_addr", inst_addr, 32'h80);
      chk("br_validD", 32'(validD), 32'd0);
      step();
      chk("r0_addr", inst_addr, 32'h80);

      // Reset mid-wait at 0x80
      rst = 1'b1;
      step();
      chk("r1_req", 32'(inst_req), 32'd0);
      chk("r1_addr", inst_addr, 32'h0);
      chk("r1_validD", 32'(validD), 32'd0);
      chk("r1_instrD", instrD, 32'h0);
      chk("r1_pcD", pcD, 32'h0);
      chk("r1_pcplus4D", pcplus4D, 32'h0);
      rst        = 1'b0;
      inst_ready = 1'b1;
      inst_rdata = word_of(32'h80);
      step();
      inst_ready = 1'b0;
      chk("r2_validD", 32'(validD), 32'd0);
      chk("r2_req", 32'(inst_req), 32'd1);
      chk("r2_addr", inst_addr, 32'h0);
      fetch_one(32'h0);

      // PC wrap at the top of the address space
      jumpD      = 1'b1;
      pcjumpD    = 32'hFFFF_FFFC;
      inst_ready = 1'b1;
      inst_rdata = word_of(32'h4);
      step();
      jumpD      = 1'b0;
      inst_ready = 1'b0;
      chk("wr_addr", inst_addr, 32'hFFFF_FFFC);
      fetch_one(32'hFFFF_FFFC);
      chk("wr_next_addr", inst_addr, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
